mac_operand_feeder: RTL and testbench

- Upstream stage of the MAC array: buffers one operand row of DEPTH bytes written by the memory-read side.
- On start, drives the MAC's control and data: one clear cycle, then DEPTH consecutive enable cycles, each presenting one buffered byte in FIFO order.
- Signals done when the row has been consumed, so the controller can read the accumulated result.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_fifo.sv | 71 +++++++
 rtl/mac_operand_feeder.sv | 127 ++++++++++++
 tb/tb_mac_operand_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: default sizes, feeder FSM states
// and the operand type. Imported by the feeder, its FIFO, the MAC and the controller.
package mac_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_t;

    typedef logic [DEF_DATA_WIDTH-1:0] operand_t;

endpackage : mac_pkg

// File: rtl/mac_fifo.sv
// Synchronous FIFO holding one operand row. The head entry is visible on
// rd_data without a read latency, so a pop and its data belong to the same edge.
module mac_fifo
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    // NOTE: all sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array.
    // NOTE: the array has no reset; count/pointers define validity, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule : mac_fifo

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the MAC array: buffers one row of DEPTH operands and, on
// start with a full row, issues one clear cycle followed by DEPTH enable cycles
// (oldest entry first), then a one-cycle done pulse. All MAC-facing outputs are registered.
// Build option: define MAC_FEED_ZERO_SKIP_EN to hold en_out low for zero operands
// during the drain (timing and a_out updates are unchanged).
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_vld,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_rdy,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  en_out,
    output logic                  clr_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_ISSUE = IDX_W'(DEPTH - 1);

    feed_state_t           state_q, state_d;
    logic [IDX_W-1:0]      issue_q, issue_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic                  en_q, en_d;
    logic                  clr_q, clr_d;
    logic                  done_q, done_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;

    mac_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_vld),
        .wr_data (wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign wr_rdy  = !fifo_full;
    assign count   = fifo_count;
    assign busy    = (state_q != IDLE);
    assign a_out   = a_q;
    assign en_out  = en_q;
    assign clr_out = clr_q;
    assign done    = done_q;

    // Next state and next registered outputs; the issue counter, not the FIFO
    // occupancy, bounds the drain so concurrent refills cannot extend the row.
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        issue_d  = issue_q;
        a_d      = a_q;
        en_d     = 1'b0;
        clr_d    = 1'b0;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && fifo_count == CNT_W'(DEPTH)) begin
                    state_d = CLEAR;
                    clr_d   = 1'b1;
                end
            end
            CLEAR: begin
                issue_d = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                fifo_pop = !fifo_empty;
                a_d      = fifo_head;
`ifdef MAC_FEED_ZERO_SKIP_EN
                en_d     = (fifo_head != '0);
`else
                en_d     = 1'b1;
`endif
                issue_d  = issue_q + 1'b1;
                if (issue_q == LAST_ISSUE) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, issue counter and registered MAC-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            issue_q <= '0;
            a_q     <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            a_q     <= a_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
        end
    end

endmodule : mac_operand_feeder

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder. A queue model of the row buffer
// and a per-row timeline derived from the start edge give the expected outputs.
module tb_mac_operand_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef MAC_FEED_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_vld;
    logic [DW-1:0]    wr_data;
    logic             wr_rdy;
    logic             start;
    logic [DW-1:0]    a_out;
    logic             en_out;
    logic             clr_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    mac_operand_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_vld  (wr_vld),
        .wr_data (wr_data),
        .wr_rdy  (wr_rdy),
        .start   (start),
        .a_out   (a_out),
        .en_out  (en_out),
        .clr_out (clr_out),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] refill_q[$];
    logic [DW-1:0] exp_a;
    int            mac_acc;

    // Packed view of the outputs: {busy, clr, en, done, count, a}
    function automatic logic [CNT_W+DW+3:0] pack(input logic b, input logic c, input logic e,
                                                 input logic d, input logic [CNT_W-1:0] n,
                                                 input logic [DW-1:0] a);
        return {b, c, e, d, n, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_vld = 1'b0; wr_data = '0; start = 1'b0;
        rst_n = 1'b0;
        model_q.delete(); refill_q.delete();
        exp_a = '0; mac_acc = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_byte(input logic [DW-1:0] v);
        bit accept;
        accept  = (model_q.size() < DEPTH);
        wr_vld  = 1'b1;
        wr_data = v;
        tick();
        wr_vld  = 1'b0;
        if (accept) model_q.push_back(v);
        n_checks++;
        if (count !== CNT_W'(model_q.size()) || wr_rdy !== (model_q.size() < DEPTH)) begin
            n_fail++;
            $display("FAIL write_%02h: count=%0d wr_rdy=%b, required count=%0d wr_rdy=%b",
                     v, count, wr_rdy, model_q.size(), model_q.size() < DEPTH);
        end
    endtask

    // Runs one row starting at the next edge. refill_q is written concurrently.
    // abort_at >= 0 asserts reset just after the check of that edge index.
    task automatic run_row(input string name, input bit hold_start, input int abort_at);
        bit            accept, pop;
        logic          exp_en;
        logic [DW-1:0] v;
        for (int e = 0; e <= DEPTH + 2; e++) begin
            wr_vld  = (refill_q.size() != 0);
            wr_data = wr_vld ? refill_q[0] : '0;
            start   = (e == 0) || hold_start;
            accept  = wr_vld && (model_q.size() < DEPTH);
            pop     = (e >= 2) && (e <= DEPTH + 1);
            tick();
            exp_en = 1'b0;
            if (pop) begin
                v      = model_q.pop_front();
                exp_a  = v;
                exp_en = SKIP ? (v != 0) : 1'b1;
            end
            if (accept) model_q.push_back(refill_q.pop_front());
            if (clr_out) mac_acc = 0;
            else if (en_out) mac_acc += int'(a_out) * 2;
            n_checks++;
            if (pack(busy, clr_out, en_out, done, count, a_out) !==
                pack(e <= DEPTH + 1, e == 0, exp_en, e == DEPTH + 2, CNT_W'(model_q.size()), exp_a)) begin
                n_fail++;
                $display("FAIL %s_e%0d: busy/clr/en/done=%b%b%b%b count=%0d a=%02h, required %b%b%b%b count=%0d a=%02h",
                         name, e, busy, clr_out, en_out, done, count, a_out,
                         e <= DEPTH + 1, e == 0, exp_en, e == DEPTH + 2, model_q.size(), exp_a);
            end
            if (e == abort_at) begin
                wr_vld = 1'b0; start = 1'b0;
                rst_n  = 1'b0;
                #1;
                model_q.delete(); refill_q.delete(); exp_a = '0;
                n_checks++;
                if (pack(busy, clr_out, en_out, done, count, a_out) !== pack(0, 0, 0, 0, 0, 0) || wr_rdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_async_rst: busy/clr/en/done=%b%b%b%b count=%0d a=%02h wr_rdy=%b, required all 0, wr_rdy=1",
                             name, busy, clr_out, en_out, done, count, a_out, wr_rdy);
                end
                tick(); tick();
                rst_n = 1'b1;
                for (int k = 0; k < DEPTH + 4; k++) begin
                    tick();
                    n_checks++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s_no_done_%0d: done=%b busy=%b, required 0 0", name, k, done, busy);
                    end
                end
                break;
            end
        end
        start  = 1'b0;
        wr_vld = 1'b0;
    endtask

    task automatic fill_row(input logic [DW-1:0] base, input bit rnd);
        for (int i = 0; i < DEPTH; i++)
            write_byte(rnd ? DW'($urandom_range(0, 255)) : base + DW'(i));
    endtask

    task automatic test_reset();
        wr_vld = 1'b0; wr_data = '0; start = 1'b0;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (pack(busy, clr_out, en_out, done, count, a_out) !== pack(0, 0, 0, 0, 0, 0) || wr_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: busy/clr/en/done=%b%b%b%b count=%0d a=%02h wr_rdy=%b, required all 0, wr_rdy=1",
                     busy, clr_out, en_out, done, count, a_out, wr_rdy);
        end
        do_reset();
        // start with an empty and then a partially filled buffer must be ignored
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
            end
            start = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                n_checks++;
                if (busy !== 1'b0 || clr_out !== 1'b0 || en_out !== 1'b0 || count !== CNT_W'(model_q.size())) begin
                    n_fail++;
                    $display("FAIL start_ignored_p%0d_%0d: busy=%b clr=%b en=%b count=%0d, required 0 0 0 %0d",
                             pass, k, busy, clr_out, en_out, count, model_q.size());
                end
            end
            start = 1'b0;
        end
        do_reset();
    endtask

    task automatic test_basic_row();
        fill_row(8'h01, 1'b0);
        run_row("basic", 1'b0, -1);
        n_checks++;
        if (!SKIP && mac_acc != 72) begin
            n_fail++;
            $display("FAIL basic_mac_acc: got %0d, required 72", mac_acc);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) write_byte(DW'(i));
        n_checks++;
        if (count !== CNT_W'(DEPTH) || wr_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_full: count=%0d wr_rdy=%b, required %0d 0", count, wr_rdy, DEPTH);
        end
        run_row("overflow", 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        fill_row(8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) refill_q.push_back(8'hA0 + DW'(i));
        run_row("overlap", 1'b1, -1);
        tick();
        n_checks++;
        if (count !== CNT_W'(DEPTH) || refill_q.size() != 0) begin
            n_fail++;
            $display("FAIL overlap_refill_count: count=%0d pending=%0d, required %0d 0", count, refill_q.size(), DEPTH);
        end
        run_row("second_row", 1'b0, -1);
    endtask

    task automatic test_reset_mid_drain();
        fill_row(8'h40, 1'b0);
        run_row("abort", 1'b0, 5);
        fill_row(8'h50, 1'b0);
        run_row("after_abort", 1'b0, -1);
    endtask

    task automatic test_zero_skip();
        logic [DW-1:0] row [DEPTH];
        for (int i = 0; i < DEPTH; i++) row[i] = (i % 2 == 0) ? 8'h00 : DW'(2 * i + 1);
        for (int i = 0; i < DEPTH; i++) write_byte(row[i]);
        run_row("zero_skip", 1'b0, -1);
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 4; r++) begin
            if (model_q.size() < DEPTH) begin
                while (model_q.size() < DEPTH) write_byte(DW'($urandom_range(0, 255)));
            end
            for (int i = 0; i < int'($urandom_range(0, DEPTH + 2)); i++)
                refill_q.push_back(DW'($urandom_range(0, 255)));
            run_row($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), -1);
            while (refill_q.size() != 0) write_byte(refill_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_overflow();
        test_back_to_back();
        tick();
        do_reset();
        test_reset_mid_drain();
        test_zero_skip();
        test_random_rows();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule : tb_mac_operand_feeder
